mem_req_arbiter: RTL and testbench

Two-client arbiter and sequencer in front of the shared backup memory port (req / req-data / resp channels).
- Grants one transaction at a time, round-robin.
- Holds the grant for a write until its data beat transfers, and for a read until all DATA_CYCLES response beats have returned.
- Prefixes the client ID onto the memory tag and routes response beats back by that ID.
- Sits between the instruction/data refill engines and the memory model.

---
 rtl/mem_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-client round-robin arbiter/sequencer for the shared backup memory port.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: client 0 always wins ties.
module mem_req_arbiter #(
    parameter int ADDR_BITS       = 28,
    parameter int DATA_BITS       = 128,
    parameter int CLIENT_TAG_BITS = 4,
    parameter int DATA_CYCLES     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    // client 0
    input  logic                         c0_req_valid,
    output logic                         c0_req_ready,
    input  logic                         c0_req_rw,
    input  logic [ADDR_BITS-1:0]         c0_req_addr,
    input  logic [CLIENT_TAG_BITS-1:0]   c0_req_tag,
    input  logic                         c0_req_data_valid,
    output logic                         c0_req_data_ready,
    input  logic [DATA_BITS-1:0]         c0_req_data_bits,
    input  logic [DATA_BITS/8-1:0]       c0_req_data_mask,
    output logic                         c0_resp_valid,
    output logic [DATA_BITS-1:0]         c0_resp_data,
    output logic [CLIENT_TAG_BITS-1:0]   c0_resp_tag,
    // client 1
    input  logic                         c1_req_valid,
    output logic                         c1_req_ready,
    input  logic                         c1_req_rw,
    input  logic [ADDR_BITS-1:0]         c1_req_addr,
    input  logic [CLIENT_TAG_BITS-1:0]   c1_req_tag,
    input  logic                         c1_req_data_valid,
    output logic                         c1_req_data_ready,
    input  logic [DATA_BITS-1:0]         c1_req_data_bits,
    input  logic [DATA_BITS/8-1:0]       c1_req_data_mask,
    output logic                         c1_resp_valid,
    output logic [DATA_BITS-1:0]         c1_resp_data,
    output logic [CLIENT_TAG_BITS-1:0]   c1_resp_tag,
    // memory
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_rw,
    output logic [ADDR_BITS-1:0]         mem_req_addr,
    output logic [CLIENT_TAG_BITS:0]     mem_req_tag,
    output logic                         mem_req_data_valid,
    input  logic                         mem_req_data_ready,
    output logic [DATA_BITS-1:0]         mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]       mem_req_data_mask,
    input  logic                         mem_resp_valid,
    input  logic [DATA_BITS-1:0]         mem_resp_data,
    input  logic [CLIENT_TAG_BITS:0]     mem_resp_tag
);
    localparam int CNT_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WDATA, RDATA} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic                       any_valid, winner;
    logic                       sel_rw;
    logic [ADDR_BITS-1:0]       sel_addr;
    logic [CLIENT_TAG_BITS-1:0] sel_tag;
    logic                       own_dvalid;
    logic                       req_fire, data_fire;

    // Tie goes to prio; otherwise whichever client is asking.
    assign any_valid = c0_req_valid | c1_req_valid;
    assign winner    = (c0_req_valid && c1_req_valid) ? prio_q : c1_req_valid;
    assign sel_rw    = winner ? c1_req_rw   : c0_req_rw;
    assign sel_addr  = winner ? c1_req_addr : c0_req_addr;
    assign sel_tag   = winner ? c1_req_tag  : c0_req_tag;

    assign own_dvalid = owner_q ? c1_req_data_valid : c0_req_data_valid;
    assign req_fire   = (state_q == IDLE) && any_valid && mem_req_ready;
    assign data_fire  = (state_q == WDATA) && own_dvalid && mem_req_data_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    owner_d = winner;
`ifdef MEM_ARB_FIXED_PRIO_EN
                    prio_d  = 1'b0;
`else
                    prio_d  = ~winner;
`endif
                    if (sel_rw) begin
                        state_d = WDATA;
                    end else begin
                        state_d    = RDATA;
                        beat_cnt_d = '0;
                    end
                end
            end
            WDATA: begin
                if (data_fire) state_d = IDLE;
            end
            RDATA: begin
                // Stray beats outside RDATA are routed but never counted.
                if (mem_resp_valid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid      = 1'b0;
        c0_req_ready       = 1'b0;
        c1_req_ready       = 1'b0;
        mem_req_data_valid = 1'b0;
        c0_req_data_ready  = 1'b0;
        c1_req_data_ready  = 1'b0;
        mem_req_rw         = sel_rw;
        mem_req_addr       = sel_addr;
        mem_req_tag        = {winner, sel_tag};
        mem_req_data_bits  = owner_q ? c1_req_data_bits : c0_req_data_bits;
        mem_req_data_mask  = owner_q ? c1_req_data_mask : c0_req_data_mask;
        if (!reset) begin
            if (state_q == IDLE) begin
                mem_req_valid = any_valid;
                c0_req_ready  = !winner && mem_req_ready;
                c1_req_ready  = winner && mem_req_ready;
            end
            if (state_q == WDATA) begin
                mem_req_data_valid = own_dvalid;
                c0_req_data_ready  = !owner_q && mem_req_data_ready;
                c1_req_data_ready  = owner_q && mem_req_data_ready;
            end
        end
    end

    assign c0_resp_valid = !reset && mem_resp_valid && !mem_resp_tag[CLIENT_TAG_BITS];
    assign c1_resp_valid = !reset && mem_resp_valid && mem_resp_tag[CLIENT_TAG_BITS];
    assign c0_resp_data  = mem_resp_data;
    assign c1_resp_data  = mem_resp_data;
    assign c0_resp_tag   = mem_resp_tag[CLIENT_TAG_BITS-1:0];
    assign c1_resp_tag   = mem_resp_tag[CLIENT_TAG_BITS-1:0];

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter against a transaction-level reference model.
module tb_mem_req_arbiter;
    localparam int AB = 28, DB = 128, CT = 4, DC = 4, MB = DB/8;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic c0_req_valid, c0_req_ready, c0_req_rw, c0_req_data_valid, c0_req_data_ready, c0_resp_valid;
    logic [AB-1:0] c0_req_addr;
    logic [CT-1:0] c0_req_tag, c0_resp_tag;
    logic [DB-1:0] c0_req_data_bits, c0_resp_data;
    logic [MB-1:0] c0_req_data_mask;
    logic c1_req_valid, c1_req_ready, c1_req_rw, c1_req_data_valid, c1_req_data_ready, c1_resp_valid;
    logic [AB-1:0] c1_req_addr;
    logic [CT-1:0] c1_req_tag, c1_resp_tag;
    logic [DB-1:0] c1_req_data_bits, c1_resp_data;
    logic [MB-1:0] c1_req_data_mask;
    logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
    logic [AB-1:0] mem_req_addr;
    logic [CT:0]   mem_req_tag, mem_resp_tag;
    logic [DB-1:0] mem_req_data_bits, mem_resp_data;
    logic [MB-1:0] mem_req_data_mask;

    always #5 clk = ~clk;

    mem_req_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .CLIENT_TAG_BITS(CT), .DATA_CYCLES(DC)) dut (
        .clk(clk), .reset(rst),
        .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_rw(c0_req_rw),
        .c0_req_addr(c0_req_addr), .c0_req_tag(c0_req_tag),
        .c0_req_data_valid(c0_req_data_valid), .c0_req_data_ready(c0_req_data_ready),
        .c0_req_data_bits(c0_req_data_bits), .c0_req_data_mask(c0_req_data_mask),
        .c0_resp_valid(c0_resp_valid), .c0_resp_data(c0_resp_data), .c0_resp_tag(c0_resp_tag),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_rw(c1_req_rw),
        .c1_req_addr(c1_req_addr), .c1_req_tag(c1_req_tag),
        .c1_req_data_valid(c1_req_data_valid), .c1_req_data_ready(c1_req_data_ready),
        .c1_req_data_bits(c1_req_data_bits), .c1_req_data_mask(c1_req_data_mask),
        .c1_resp_valid(c1_resp_valid), .c1_resp_data(c1_resp_data), .c1_resp_tag(c1_resp_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
    );

    int n_checks = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what the port is busy with, who owns it, who gets the next tie.
    typedef enum {M_FREE, M_WRITE, M_READ} mode_e;
    mode_e mode = M_FREE;
    bit    owner = 1'b0, favour = 1'b0;
    int    beats_left = 0;

    function automatic bit pick();
        if (c0_req_valid && c1_req_valid) return favour;
        return c1_req_valid;
    endfunction

    task automatic settle();
        bit w;
        logic [CT:0] et;
        #1;
        if (rst) begin
            chk("rst_mreqv", mem_req_valid, 0);
            chk("rst_mdatav", mem_req_data_valid, 0);
            chk("rst_rdy", {c0_req_ready, c1_req_ready, c0_req_data_ready, c1_req_data_ready}, 0);
            chk("rst_resp", {c0_resp_valid, c1_resp_valid}, 0);
            return;
        end
        chk("c0_respv", c0_resp_valid, mem_resp_valid && (mem_resp_tag[CT] == 1'b0));
        chk("c1_respv", c1_resp_valid, mem_resp_valid && (mem_resp_tag[CT] == 1'b1));
        chk("resp_data", {c0_resp_data ^ c1_resp_data, c0_resp_data}, {128'h0, mem_resp_data});
        chk("resp_tag", {c0_resp_tag, c1_resp_tag}, {mem_resp_tag[CT-1:0], mem_resp_tag[CT-1:0]});
        if (mode == M_FREE) begin
            chk("mreqv", mem_req_valid, c0_req_valid | c1_req_valid);
            if (c0_req_valid | c1_req_valid) begin
                w  = pick();
                et = {w, w ? c1_req_tag : c0_req_tag};
                chk("mreq_tag", mem_req_tag, et);
                chk("mreq_rw", mem_req_rw, w ? c1_req_rw : c0_req_rw);
                chk("mreq_addr", mem_req_addr, w ? c1_req_addr : c0_req_addr);
                chk("c0_rdy", c0_req_ready, !w && mem_req_ready);
                chk("c1_rdy", c1_req_ready, w && mem_req_ready);
            end
        end else begin
            chk("busy_mreqv", mem_req_valid, 0);
            chk("busy_rdy", {c0_req_ready, c1_req_ready}, 0);
        end
        if (mode == M_WRITE) begin
            chk("mdatav", mem_req_data_valid, owner ? c1_req_data_valid : c0_req_data_valid);
            chk("mdata", mem_req_data_bits, owner ? c1_req_data_bits : c0_req_data_bits);
            chk("mmask", mem_req_data_mask, owner ? c1_req_data_mask : c0_req_data_mask);
            chk("c0_drdy", c0_req_data_ready, !owner && mem_req_data_ready);
            chk("c1_drdy", c1_req_data_ready, owner && mem_req_data_ready);
        end else begin
            chk("nw_mdatav", mem_req_data_valid, 0);
            chk("nw_drdy", {c0_req_data_ready, c1_req_data_ready}, 0);
        end
    endtask

    task automatic tick();
        bit w;
        if (rst) begin
            mode = M_FREE; owner = 1'b0; favour = 1'b0; beats_left = 0;
        end else begin
            case (mode)
                M_FREE: if ((c0_req_valid | c1_req_valid) && mem_req_ready) begin
                    w = pick();
                    owner = w;
                    if (!FIXED) favour = !w;
                    if (w ? c1_req_rw : c0_req_rw) mode = M_WRITE;
                    else begin mode = M_READ; beats_left = DC; end
                end
                M_WRITE: if ((owner ? c1_req_data_valid : c0_req_data_valid) && mem_req_data_ready)
                    mode = M_FREE;
                M_READ: if (mem_resp_valid) begin
                    beats_left--;
                    if (beats_left == 0) mode = M_FREE;
                end
            endcase
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        c0_req_valid = 0; c0_req_rw = 0; c0_req_addr = '0; c0_req_tag = '0;
        c0_req_data_valid = 0; c0_req_data_bits = '0; c0_req_data_mask = '0;
        c1_req_valid = 0; c1_req_rw = 0; c1_req_addr = '0; c1_req_tag = '0;
        c1_req_data_valid = 0; c1_req_data_bits = '0; c1_req_data_mask = '0;
        mem_req_ready = 1; mem_req_data_ready = 1;
        mem_resp_valid = 0; mem_resp_data = '0; mem_resp_tag = '0;
    endtask

    task automatic rand_in();
        c0_req_valid = ($urandom % 3) != 0; c0_req_rw = $urandom % 2;
        c0_req_addr = AB'($urandom); c0_req_tag = CT'($urandom);
        c0_req_data_valid = $urandom % 2; c0_req_data_mask = MB'($urandom);
        c0_req_data_bits = {$urandom, $urandom, $urandom, $urandom};
        c1_req_valid = ($urandom % 3) != 0; c1_req_rw = $urandom % 2;
        c1_req_addr = AB'($urandom); c1_req_tag = CT'($urandom);
        c1_req_data_valid = $urandom % 2; c1_req_data_mask = MB'($urandom);
        c1_req_data_bits = {$urandom, $urandom, $urandom, $urandom};
        mem_req_ready = ($urandom % 4) != 0; mem_req_data_ready = ($urandom % 4) != 0;
        mem_resp_valid = $urandom % 2; mem_resp_tag = (CT+1)'($urandom);
        mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        rst = 1; settle(); tick(); rst = 0;
    endtask

    initial begin
        int n0, n1;
        logic g;
        quiet();
        @(negedge clk);
        do_reset();

        // c0 read, four beats back to c0 only
        c0_req_valid = 1; c0_req_rw = 0; c0_req_addr = AB'(32'h40); c0_req_tag = 4'h3;
        settle(); chk("t1_tag", mem_req_tag, 5'h03); tick();
        quiet(); n0 = 0; n1 = 0;
        for (int i = 0; i < DC; i++) begin
            mem_resp_valid = 1; mem_resp_tag = 5'h03; mem_resp_data = {4{$urandom}};
            settle(); n0 += int'(c0_resp_valid); n1 += int'(c1_resp_valid);
            chk("t1_rtag", c0_resp_tag, 4'h3); tick();
        end
        chk("t1_beats0", n0, DC); chk("t1_beats1", n1, 0);
        quiet(); mem_req_ready = 0; c1_req_valid = 1;
        settle(); chk("t1_idle", mem_req_valid, 1); tick();

        // contention: writes from both, data ready immediately
        quiet(); do_reset();
        for (int i = 0; i < 3; i++) begin
            c0_req_valid = 1; c1_req_valid = 1; c0_req_rw = 1; c1_req_rw = 1;
            c0_req_data_valid = 1; c1_req_data_valid = 1;
            settle(); g = mem_req_tag[CT]; tick();
            settle(); tick();
            chk("t2_grant", g, FIXED ? 1'b0 : ((i % 2) == 1));
        end

        // c1 write with late data while c0 waits
        quiet(); do_reset();
        c1_req_valid = 1; c1_req_rw = 1; c1_req_addr = AB'(32'h80); c1_req_tag = 4'h5;
        settle(); chk("t3_addr", mem_req_addr, AB'(32'h80)); tick();
        c1_req_valid = 0; c0_req_valid = 1; c0_req_rw = 0;
        for (int i = 0; i < 2; i++) begin
            settle(); chk("t3_wait", c0_req_ready, 0); tick();
        end
        c1_req_data_valid = 1; c1_req_data_mask = 16'h00FF; c1_req_data_bits = {4{$urandom}};
        settle(); chk("t3_dv", mem_req_data_valid, 1); chk("t3_mask", mem_req_data_mask, 16'h00FF);
        chk("t3_c0rdy", c0_req_ready, 0); tick();
        settle(); chk("t3_single", mem_req_data_valid, 0); chk("t3_after", c0_req_ready, 1); tick();
        quiet();
        for (int i = 0; i < DC; i++) begin mem_resp_valid = 1; settle(); tick(); end

        // early data from c0 with nothing granted
        quiet(); c0_req_data_valid = 1;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("t4_early", {mem_req_data_valid, c0_req_data_ready}, 0); tick();
        end

        // reset in the middle of a read, then a full read afterwards
        quiet(); c0_req_valid = 1; settle(); tick();
        c0_req_valid = 0;
        for (int i = 0; i < 2; i++) begin mem_resp_valid = 1; settle(); tick(); end
        c0_req_valid = 1; rst = 1;
        settle(); chk("t5_rst", {mem_req_valid, c0_req_ready, c0_resp_valid}, 0); tick();
        rst = 0; settle(); tick();
        quiet(); c1_req_valid = 1;
        for (int i = 0; i < DC - 1; i++) begin
            mem_resp_valid = 1; settle(); chk("t5_busy", mem_req_valid, 0); tick();
        end
        mem_resp_valid = 1; mem_req_ready = 0; settle(); tick();
        mem_resp_valid = 0; settle(); chk("t5_free", mem_req_valid, 1); tick();

        // random traffic with occasional resets
        quiet(); do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            rst = ($urandom % 250) == 0;
            settle(); tick();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
